serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that computes a WIDTH-bit sum using one shared `full_adder` instance. The controller latches two operands, feeds the operands to the adder one bit per clock with the carry held in a flip-flop, and presents the registered result with a `done` pulse. It sits in place of a WIDTH-bit ripple adder wherever area matters more than latency.

---
 rtl/serial_adder_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder that reuses one full_adder cell for all
// WIDTH bits. The operands are shifted out LSB first. The carry is held in a
// flip-flop between bits. The finished sum is registered and flagged with a
// one-cycle done pulse.

// One-bit full adder cell. The controller shares this single cell across all bits.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c_q;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] s_next;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (c_q),
    .s  (fa_sum),
    .co (fa_cout)
  );

  // New partial sum: the fresh bit enters at the MSB. This form also works for WIDTH=1.
  always_comb begin
    s_next = (s_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  end

  // Controller FSM. It owns every register, including the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            c_q   <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= s_next;
          c_q  <= fa_cout;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= s_next;
            cout  <= fa_cout;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl. An 8-bit instance is used for directed
// cases. A 4-bit instance is swept over every operand combination. Expected
// results are queued when stimulus is issued. Monitors pop and compare them on each done.

module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [8:0] e8;
  logic [4:0] e4;

  int nPass = 0;
  int nChecks = 0;
  int done8Count = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  // Free-running clock with a 10 ns period
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else
      nPass++;
  endtask

  // Issue one request to the 8-bit instance. Optionally queue its expected result.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                               input bit push);
    @(negedge clk);
    a8 = av;
    b8 = bv;
    cin8 = cv;
    start8 = 1'b1;
    if (push) q8.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cv});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Count edges until done8 is seen, along with samples where busy8 was high.
  task automatic waitDone8(output int edges, output int busyCnt);
    edges = 0;
    busyCnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done8) return;
      if (busy8) busyCnt++;
    end
    checkOutput("timeout8", 0, 1);
  endtask

  // Scoreboard monitor for the 8-bit instance
  always @(negedge clk) begin
    if (done8) begin
      done8Count++;
      if (q8.size() == 0) begin
        checkOutput("unexpected_done8", {cout8, sum8}, 9'h1FF);
      end else begin
        e8 = q8.pop_front();
        checkOutput("result8", {55'd0, cout8, sum8}, {55'd0, e8});
      end
    end
  end

  // Scoreboard monitor for the 4-bit instance
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        checkOutput("unexpected_done4", {cout4, sum4}, 5'h1F);
      end else begin
        e4 = q4.pop_front();
        checkOutput("result4", {59'd0, cout4, sum4}, {59'd0, e4});
      end
    end
  end

  // Watchdog so the bench can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence for the 8-bit instance, then the 4-bit sweep
  initial begin
    int edges, busyCnt, prev;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy8, 0);
    checkOutput("reset_done", done8, 0);
    checkOutput("reset_sum", sum8, 0);
    checkOutput("reset_cout", cout8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic add 5A+3C+1");
    applyStimulus(8'h5A, 8'h3C, 1'b1, 1);
    checkOutput("busy_after_accept", busy8, 1);
    waitDone8(edges, busyCnt);
    checkOutput("latency_basic", edges, 8);
    checkOutput("busy_run_samples", busyCnt, 7);
    checkOutput("busy_at_done", busy8, 0);

    $display("[TB] carry propagation");
    applyStimulus(8'hFF, 8'h01, 1'b0, 1);
    waitDone8(edges, busyCnt);
    checkOutput("latency_carry", edges, 8);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1);
    waitDone8(edges, busyCnt);

    $display("[TB] start ignored during run");
    applyStimulus(8'h12, 8'h34, 1'b0, 1);
    repeat (3) @(posedge clk);
    applyStimulus(8'hAA, 8'h55, 1'b1, 0);
    waitDone8(edges, busyCnt);
    @(negedge clk);
    #1;
    prev = done8Count;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("no_second_done", done8Count, prev);

    $display("[TB] result held during next run");
    applyStimulus(8'h01, 8'h01, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("held_sum", sum8, 8'h46);
      checkOutput("held_cout", cout8, 0);
    end
    waitDone8(edges, busyCnt);

    $display("[TB] back-to-back");
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h030);
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
    q8.push_back(9'h101);
    waitDone8(edges, busyCnt);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    waitDone8(edges, busyCnt);
    checkOutput("b2b_gap", edges + 1, 9);

    $display("[TB] reset mid-operation");
    applyStimulus(8'h77, 8'h11, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_before_reset", busy8, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy8, 0);
    checkOutput("midrst_done", done8, 0);
    checkOutput("midrst_sum", sum8, 0);
    checkOutput("midrst_cout", cout8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev = done8Count;
    repeat (15) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("no_done_after_reset", done8Count, prev);

    $display("[TB] exhaustive 4-bit sweep");
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          bit seen;
          @(negedge clk);
          a4 = 4'(ai);
          b4 = 4'(bi);
          cin4 = 1'(ci);
          start4 = 1'b1;
          q4.push_back(5'(ai + bi + ci));
          @(negedge clk);
          start4 = 1'b0;
          seen = 0;
          for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (done4) seen = 1;
          end
          if (!seen) checkOutput("timeout4", 0, 1);
        end
      end
    end

    repeat (2) @(negedge clk);
    #1;
    checkOutput("queue8_empty", q8.size(), 0);
    checkOutput("queue4_empty", q4.size(), 0);
    checkOutput("done8_total", done8Count, 7);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
